id_operand_stage: RTL and testbench

//  Registered decode/operand stage for the RV32I pipeline: accepts a decoded instruction, resolves rs1/rs2

---
 rtl/id_pkg.sv | 21 ++
 rtl/id_scoreboard.sv | 65 ++++++
 rtl/id_operand_stage.sv | 183 ++++++++++++++++++
 tb/tb_id_operand_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared types and constants for the decode/operand stage: defaults, register-zero
// constant, scoreboard limit helper and the operand-source encoding.
package id_pkg;

    localparam int ID_XLEN    = 32;
    localparam int ID_RADDR_W = 5;
    localparam int REG_ZERO   = 0;

    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_BYP,
        SRC_REL,
        SRC_RF,
        SRC_WAIT
    } src_e;

    function automatic int sb_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Per-register outstanding-write counters with increment, release and flush-release
// inputs, plus busy/full lookups for three addresses (rs1, rs2, rd).
module id_scoreboard
    import id_pkg::*;
#(
    parameter int RADDR_W  = ID_RADDR_W,
    parameter int SB_CNT_W = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 inc_en,
    input  logic [RADDR_W-1:0]   inc_addr,
    input  logic                 dec_en,
    input  logic [RADDR_W-1:0]   dec_addr,
    input  logic                 fdec_en,
    input  logic [RADDR_W-1:0]   fdec_addr,
    input  logic [3*RADDR_W-1:0] q_addr,
    output logic [2:0]           q_busy,
    output logic [2:0]           q_full
);

    localparam int NREG = 1 << RADDR_W;
    localparam logic [SB_CNT_W-1:0] CNT_MAX = SB_CNT_W'(sb_max(SB_CNT_W));

    logic [SB_CNT_W-1:0] r_cnt [NREG];

    // Increment and the two kinds of release merge arithmetically; the result
    // never drops below zero, so a stray release of an idle register is harmless.
    function automatic logic [SB_CNT_W-1:0] next_cnt(
        input logic [SB_CNT_W-1:0] cnt,
        input logic                inc,
        input logic                dec,
        input logic                fdec
    );
        int v;
        v = int'(cnt) + int'(inc) - int'(dec) - int'(fdec);
        if (v < 0) v = 0;
        if (v > int'(CNT_MAX)) v = int'(CNT_MAX);
        return SB_CNT_W'(v);
    endfunction

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else begin
            r_cnt[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                r_cnt[i] <= next_cnt(r_cnt[i],
                                     inc_en  && (inc_addr  == RADDR_W'(i)),
                                     dec_en  && (dec_addr  == RADDR_W'(i)),
                                     fdec_en && (fdec_addr == RADDR_W'(i)));
            end
        end
    end

    always_comb begin
        q_busy = '0;
        q_full = '0;
        for (int j = 0; j < 3; j++) begin
            q_busy[j] = (r_cnt[q_addr[j*RADDR_W +: RADDR_W]] != '0);
            q_full[j] = (r_cnt[q_addr[j*RADDR_W +: RADDR_W]] == CNT_MAX);
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// RV32I decode/operand stage: resolves rs1/rs2 from bypass, writeback or regfile,
// gates issue on the scoreboard and hands operands to EX through a valid/ready latch.
module id_operand_stage
    import id_pkg::*;
#(
    parameter int XLEN     = ID_XLEN,
    parameter int RADDR_W  = ID_RADDR_W,
    parameter int NUM_BYP  = 2,
    parameter int SB_CNT_W = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_pc,
    input  logic                      in_rs1_req,
    input  logic [RADDR_W-1:0]        in_rs1_addr,
    input  logic                      in_rs2_req,
    input  logic [RADDR_W-1:0]        in_rs2_addr,
    input  logic                      in_rd_write,
    input  logic [RADDR_W-1:0]        in_rd_addr,
    output logic [RADDR_W-1:0]        rf_raddr1,
    input  logic [XLEN-1:0]           rf_rdata1,
    output logic [RADDR_W-1:0]        rf_raddr2,
    input  logic [XLEN-1:0]           rf_rdata2,
    input  logic [NUM_BYP-1:0]        byp_valid,
    input  logic [NUM_BYP-1:0]        byp_ready,
    input  logic [NUM_BYP*RADDR_W-1:0] byp_addr,
    input  logic [NUM_BYP*XLEN-1:0]   byp_data,
    input  logic                      rel_valid,
    input  logic                      rel_write,
    input  logic [RADDR_W-1:0]        rel_addr,
    input  logic [XLEN-1:0]           rel_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [XLEN-1:0]           out_rs1_data,
    output logic [XLEN-1:0]           out_rs2_data,
    output logic [RADDR_W-1:0]        out_rd_addr,
    output logic                      out_rd_write,
    output logic                      stall_o
);

    localparam logic [RADDR_W-1:0] X0 = RADDR_W'(REG_ZERO);

    typedef struct packed {
        src_e            src;
        logic [XLEN-1:0] data;
    } opnd_t;

    logic            r_out_valid;
    logic [XLEN-1:0] r_out_pc;
    logic [XLEN-1:0] r_out_rs1;
    logic [XLEN-1:0] r_out_rs2;
    logic [RADDR_W-1:0] r_out_rd;
    logic            r_out_rd_write;

    logic [2:0] w_busy;
    logic [2:0] w_full;
    opnd_t      w_op1;
    opnd_t      w_op2;
    logic       w_rd_full_blk;
    logic       w_ops_ok;
    logic       w_accept;
    logic       w_inc_en;
    logic       w_dec_en;
    logic       w_fdec_en;

    // Channels are scanned high to low so the lowest-numbered (youngest) match wins.
    function automatic opnd_t resolve(
        input logic                       req,
        input logic [RADDR_W-1:0]         addr,
        input logic                       busy,
        input logic [XLEN-1:0]            rf_data,
        input logic [NUM_BYP-1:0]         bv,
        input logic [NUM_BYP-1:0]         br,
        input logic [NUM_BYP*RADDR_W-1:0] ba,
        input logic [NUM_BYP*XLEN-1:0]    bd,
        input logic                       rv,
        input logic                       rw,
        input logic [RADDR_W-1:0]         ra,
        input logic [XLEN-1:0]            rdat
    );
        opnd_t r;
        logic  hit;
        r.src  = SRC_RF;
        r.data = rf_data;
        hit    = 1'b0;
        if (!req || addr == X0) begin
            r.src  = SRC_ZERO;
            r.data = '0;
        end else begin
            for (int k = NUM_BYP - 1; k >= 0; k--) begin
                if (bv[k] && ba[k*RADDR_W +: RADDR_W] == addr) begin
                    hit    = 1'b1;
                    r.src  = br[k] ? SRC_BYP : SRC_WAIT;
                    r.data = bd[k*XLEN +: XLEN];
                end
            end
            if (!hit) begin
                if (rv && rw && ra == addr) begin
                    r.src  = SRC_REL;
                    r.data = rdat;
                end else if (busy) begin
                    r.src = SRC_WAIT;
                end
            end
        end
        return r;
    endfunction

    id_scoreboard #(
        .RADDR_W  (RADDR_W),
        .SB_CNT_W (SB_CNT_W)
    ) u_sb (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .inc_en    (w_inc_en),
        .inc_addr  (in_rd_addr),
        .dec_en    (w_dec_en),
        .dec_addr  (rel_addr),
        .fdec_en   (w_fdec_en),
        .fdec_addr (r_out_rd),
        .q_addr    ({in_rd_addr, in_rs2_addr, in_rs1_addr}),
        .q_busy    (w_busy),
        .q_full    (w_full)
    );

    always_comb begin
        w_op1 = resolve(in_rs1_req, in_rs1_addr, w_busy[0], rf_rdata1,
                        byp_valid, byp_ready, byp_addr, byp_data,
                        rel_valid, rel_write, rel_addr, rel_data);
        w_op2 = resolve(in_rs2_req, in_rs2_addr, w_busy[1], rf_rdata2,
                        byp_valid, byp_ready, byp_addr, byp_data,
                        rel_valid, rel_write, rel_addr, rel_data);
    end

    // A full rd counter only blocks issue if no release of that rd frees a slot now.
    assign w_rd_full_blk = in_rd_write && (in_rd_addr != X0) && w_full[2]
                           && !(rel_valid && rel_addr == in_rd_addr);
    assign w_ops_ok  = (w_op1.src != SRC_WAIT) && (w_op2.src != SRC_WAIT) && !w_rd_full_blk;
    assign in_ready  = w_ops_ok && (!r_out_valid || out_ready) && !flush;
    assign stall_o   = in_valid && !w_ops_ok;
    assign w_accept  = in_valid && in_ready;

    assign w_inc_en  = w_accept && in_rd_write && (in_rd_addr != X0);
    assign w_dec_en  = rel_valid && (rel_addr != X0);
    assign w_fdec_en = flush && r_out_valid && r_out_rd_write && (r_out_rd != X0);

    assign rf_raddr1 = in_rs1_addr;
    assign rf_raddr2 = in_rs2_addr;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_pc       <= '0;
            r_out_rs1      <= '0;
            r_out_rs2      <= '0;
            r_out_rd       <= '0;
            r_out_rd_write <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid    <= 1'b1;
            r_out_pc       <= in_pc;
            r_out_rs1      <= w_op1.data;
            r_out_rs2      <= w_op2.data;
            r_out_rd       <= in_rd_addr;
            r_out_rd_write <= in_rd_write;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_pc       = r_out_pc;
    assign out_rs1_data = r_out_rs1;
    assign out_rs2_data = r_out_rs2;
    assign out_rd_addr  = r_out_rd;
    assign out_rd_write = r_out_rd_write;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: reset, x0, load-use, priority, scoreboard limit,
// backpressure/flush and mid-stream reset.
module tb_id_operand_stage;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int NUM_BYP = 2;

    logic                       clk_in = 1'b0;
    logic                       rst_n;
    logic                       in_valid, in_ready;
    logic [XLEN-1:0]            in_pc;
    logic                       in_rs1_req, in_rs2_req, in_rd_write;
    logic [RADDR_W-1:0]         in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [RADDR_W-1:0]         rf_raddr1, rf_raddr2;
    logic [XLEN-1:0]            rf_rdata1, rf_rdata2;
    logic [NUM_BYP-1:0]         byp_valid, byp_ready;
    logic [NUM_BYP*RADDR_W-1:0] byp_addr;
    logic [NUM_BYP*XLEN-1:0]    byp_data;
    logic                       rel_valid, rel_write;
    logic [RADDR_W-1:0]         rel_addr;
    logic [XLEN-1:0]            rel_data;
    logic                       flush;
    logic                       out_valid, out_ready;
    logic [XLEN-1:0]            out_pc, out_rs1_data, out_rs2_data;
    logic [RADDR_W-1:0]         out_rd_addr;
    logic                       out_rd_write;
    logic                       stall_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    id_operand_stage #(
        .XLEN(XLEN), .RADDR_W(RADDR_W), .NUM_BYP(NUM_BYP), .SB_CNT_W(2)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1_req(in_rs1_req), .in_rs1_addr(in_rs1_addr),
        .in_rs2_req(in_rs2_req), .in_rs2_addr(in_rs2_addr),
        .in_rd_write(in_rd_write), .in_rd_addr(in_rd_addr),
        .rf_raddr1(rf_raddr1), .rf_rdata1(rf_rdata1),
        .rf_raddr2(rf_raddr2), .rf_rdata2(rf_rdata2),
        .byp_valid(byp_valid), .byp_ready(byp_ready),
        .byp_addr(byp_addr), .byp_data(byp_data),
        .rel_valid(rel_valid), .rel_write(rel_write),
        .rel_addr(rel_addr), .rel_data(rel_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd_addr(out_rd_addr), .out_rd_write(out_rd_write),
        .stall_o(stall_o)
    );

    task automatic idle();
        in_valid = 0; in_pc = '0;
        in_rs1_req = 0; in_rs1_addr = '0; in_rs2_req = 0; in_rs2_addr = '0;
        in_rd_write = 0; in_rd_addr = '0;
        rf_rdata1 = '0; rf_rdata2 = '0;
        byp_valid = '0; byp_ready = '0; byp_addr = '0; byp_data = '0;
        rel_valid = 0; rel_write = 0; rel_addr = '0; rel_data = '0;
        flush = 0; out_ready = 1;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_out_pc got=%0h exp=0", out_pc); end
        checks++; if (out_rs1_data !== 32'h0) begin errors++; $display("FAIL rst_out_rs1 got=%0h exp=0", out_rs1_data); end
        checks++; if (out_rd_write !== 1'b0) begin errors++; $display("FAIL rst_out_rd_write got=%0h exp=0", out_rd_write); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
        rst_n = 1;
        step();
    endtask

    task automatic test_x0();
        do_reset();
        in_valid = 1; in_pc = 32'h40;
        in_rs1_req = 1; in_rs1_addr = 5'd0;
        in_rs2_req = 1; in_rs2_addr = 5'd0; rf_rdata2 = 32'hABCD;
        byp_valid = 2'b01; byp_ready = 2'b01; byp_addr = {5'd0, 5'd0}; byp_data = {32'h0, 32'hFF};
        in_rd_write = 1; in_rd_addr = 5'd0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (in_ready !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL x0_no_stall[%0d] got in_ready=%0h stall=%0h exp 1/0", i, in_ready, stall_o); end
            step();
        end
        checks++; if (out_rs1_data !== 32'h0) begin errors++; $display("FAIL x0_rs1 got=%0h exp=0", out_rs1_data); end
        checks++; if (out_rs2_data !== 32'h0) begin errors++; $display("FAIL x0_rs2 got=%0h exp=0", out_rs2_data); end
        checks++; if (out_valid !== 1'b1 || out_rd_addr !== 5'd0) begin errors++; $display("FAIL x0_out got valid=%0h rd=%0d exp 1/0", out_valid, out_rd_addr); end
        idle();
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        byp_valid = 2'b01; byp_ready = 2'b00; byp_addr = {5'd0, 5'd3}; byp_data = '0;
        in_valid = 1; in_pc = 32'h100;
        in_rs1_req = 1; in_rs1_addr = 5'd3;
        in_rd_write = 1; in_rd_addr = 5'd10;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0h exp=1", stall_o); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_in_ready_low got=%0h exp=0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_no_issue got=%0h exp=0", out_valid); end
        byp_ready = 2'b01; byp_data = {32'h0, 32'hDEADBEEF};
        #1;
        checks++; if (in_ready !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL lu_resume got in_ready=%0h stall=%0h exp 1/0", in_ready, stall_o); end
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lu_out_valid got=%0h exp=1", out_valid); end
        checks++; if (out_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lu_rs1 got=%0h exp=deadbeef", out_rs1_data); end
        checks++; if (out_pc !== 32'h100 || out_rd_addr !== 5'd10) begin errors++; $display("FAIL lu_pc_rd got pc=%0h rd=%0d exp 100/10", out_pc, out_rd_addr); end
        idle();
        step();
    endtask

    task automatic test_priority();
        do_reset();
        in_valid = 1; in_pc = 32'h80;
        in_rs1_req = 1; in_rs1_addr = 5'd7; rf_rdata1 = 32'h44;
        in_rs2_req = 1; in_rs2_addr = 5'd8; rf_rdata2 = 32'h55;
        byp_valid = 2'b11; byp_ready = 2'b11; byp_addr = {5'd7, 5'd7}; byp_data = {32'h22, 32'h11};
        rel_valid = 1; rel_write = 1; rel_addr = 5'd7; rel_data = 32'h33;
        #1;
        checks++; if (rf_raddr1 !== 5'd7 || rf_raddr2 !== 5'd8) begin errors++; $display("FAIL pri_raddr got %0d/%0d exp 7/8", rf_raddr1, rf_raddr2); end
        step();
        checks++; if (out_rs1_data !== 32'h11) begin errors++; $display("FAIL pri_byp0 got=%0h exp=11", out_rs1_data); end
        checks++; if (out_rs2_data !== 32'h55) begin errors++; $display("FAIL pri_rs2_rf got=%0h exp=55", out_rs2_data); end
        byp_valid = 2'b10;
        step();
        checks++; if (out_rs1_data !== 32'h22) begin errors++; $display("FAIL pri_byp1 got=%0h exp=22", out_rs1_data); end
        byp_valid = 2'b00;
        step();
        checks++; if (out_rs1_data !== 32'h33) begin errors++; $display("FAIL pri_rel got=%0h exp=33", out_rs1_data); end
        rel_valid = 0;
        step();
        checks++; if (out_rs1_data !== 32'h44 || out_valid !== 1'b1) begin errors++; $display("FAIL pri_rf got=%0h valid=%0h exp 44/1", out_rs1_data, out_valid); end
        idle();
        step();
    endtask

    task automatic test_scoreboard();
        do_reset();
        in_valid = 1; in_rd_write = 1; in_rd_addr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sb_issue[%0d] got=%0h exp=1", i, in_ready); end
            step();
        end
        checks++; if (in_ready !== 1'b0 || stall_o !== 1'b1) begin errors++; $display("FAIL sb_full_stall got in_ready=%0h stall=%0h exp 0/1", in_ready, stall_o); end
        rel_valid = 1; rel_write = 0; rel_addr = 5'd9;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sb_rel_accept got=%0h exp=1", in_ready); end
        step();
        rel_valid = 0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sb_still_full got=%0h exp=0", in_ready); end
        in_valid = 0; in_rd_write = 0;
        rel_valid = 1;
        for (int i = 0; i < 3; i++) step();
        rel_valid = 0;
        in_valid = 1; in_rs1_req = 1; in_rs1_addr = 5'd9;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sb_drained got=%0h exp=1", in_ready); end
        idle();
        step();
    endtask

    task automatic test_backpressure_flush();
        do_reset();
        in_valid = 1; in_pc = 32'h200;
        in_rs1_req = 1; in_rs1_addr = 5'd2; rf_rdata1 = 32'h1234;
        in_rd_write = 1; in_rd_addr = 5'd4;
        step();
        in_valid = 0; out_ready = 0; rf_rdata1 = 32'h0; in_pc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin errors++; $display("FAIL bp_hold_pc[%0d] got valid=%0h pc=%0h exp 1/200", i, out_valid, out_pc); end
            checks++; if (out_rs1_data !== 32'h1234 || out_rd_addr !== 5'd4) begin errors++; $display("FAIL bp_hold_data[%0d] got rs1=%0h rd=%0d exp 1234/4", i, out_rs1_data, out_rd_addr); end
            step();
        end
        in_valid = 1; in_pc = 32'h300; in_rs1_req = 0; in_rd_write = 0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0h exp=0", in_ready); end
        flush = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready got=%0h exp=0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_out_valid got=%0h exp=0", out_valid); end
        flush = 0; out_ready = 1;
        in_rs1_req = 1; in_rs1_addr = 5'd4; rf_rdata1 = 32'h77;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_count_dec got in_ready=%0h exp=1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h77 || out_pc !== 32'h300) begin errors++; $display("FAIL fl_next got valid=%0h rs1=%0h pc=%0h exp 1/77/300", out_valid, out_rs1_data, out_pc); end
        idle();
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1; in_rd_write = 1; in_rd_addr = 5'd5; in_pc = 32'h500;
        step();
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got=%0h exp=1", out_valid); end
        in_valid = 0; out_ready = 0;
        #2;
        rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin errors++; $display("FAIL rm_async got valid=%0h pc=%0h exp 0/0", out_valid, out_pc); end
        #1;
        rst_n = 1;
        in_valid = 1; in_rs1_req = 1; in_rs1_addr = 5'd5; in_rd_write = 1; in_rd_addr = 5'd5;
        #1;
        checks++; if (in_ready !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL rm_counts_clear got in_ready=%0h stall=%0h exp 1/0", in_ready, stall_o); end
        idle();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_x0();
        test_load_use();
        test_priority();
        test_scoreboard();
        test_backpressure_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
